// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects the twelve raw player pins, turning them
// into one-cycle column/confirm/new-game events and debounced mode levels.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] pins_in,
  output logic        col_valid,
  output logic [2:0]  col_idx,
  output logic        multi_press,
  output logic        confirm_pulse,
  output logic        newgame_pulse,
  output logic        switch_player_lvl,
  output logic        pvp_lvl,
  output logic        debug_lvl
);

  localparam int unsigned NPINS = 12;
  localparam int unsigned NCOLS = 7;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PIN_CONFIRM = 7;
  localparam int unsigned PIN_SWITCH  = 8;
  localparam int unsigned PIN_PVP     = 9;
  localparam int unsigned PIN_NEWGAME = 10;
  localparam int unsigned PIN_DEBUG   = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NPINS-1:0] sync1_q, sync2_q;
  logic [NPINS-1:0] stab_q, stab_d;
  // Previous stable value: feeds the rise detector and doubles as the registered level.
  logic [NPINS-1:0] stab_prev_q;
  logic [CNT_W-1:0] cnt_q [NPINS];
  logic [CNT_W-1:0] cnt_d [NPINS];

  logic       col_valid_q, col_valid_d;
  logic [2:0] col_idx_q, col_idx_d;
  logic       multi_press_q, multi_press_d;
  logic       confirm_q, confirm_d;
  logic       newgame_q, newgame_d;

  logic       rise_col, rise_confirm, rise_newgame;
  logic       cols_onehot, discard;
  logic [2:0] onehot_idx;

  // Per-pin debounce: a mismatch must persist DEBOUNCE_CYCLES cycles before it is accepted.
  always_comb begin
    stab_d = stab_q;
    for (int i = 0; i < NPINS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stab_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stab_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Event decode on rising edges of the debounced pins.
  always_comb begin
    rise_col     = |(stab_q[NCOLS-1:0] & ~stab_prev_q[NCOLS-1:0]);
    rise_confirm = stab_q[PIN_CONFIRM] & ~stab_prev_q[PIN_CONFIRM];
    rise_newgame = stab_q[PIN_NEWGAME] & ~stab_prev_q[PIN_NEWGAME];
    cols_onehot  = $onehot(stab_q[NCOLS-1:0]);
    onehot_idx   = 3'd0;
    for (int i = 0; i < NCOLS; i++) begin
      if (stab_q[i]) begin
        onehot_idx = 3'(i);
      end
    end
    // A new-game press swallows any column/confirm event arriving in the same cycle.
    discard       = rise_newgame & (rise_col | rise_confirm);
    col_valid_d   = rise_col & cols_onehot & ~discard;
    multi_press_d = rise_col & ~cols_onehot & ~discard;
    confirm_d     = rise_confirm & ~discard;
    newgame_d     = rise_newgame;
    col_idx_d     = col_valid_d ? onehot_idx : col_idx_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stab_q        <= '0;
      stab_prev_q   <= '0;
      cnt_q         <= '{default: '0};
      col_valid_q   <= 1'b0;
      col_idx_q     <= 3'd0;
      multi_press_q <= 1'b0;
      confirm_q     <= 1'b0;
      newgame_q     <= 1'b0;
    end else begin
      sync1_q       <= pins_in;
      sync2_q       <= sync1_q;
      stab_q        <= stab_d;
      stab_prev_q   <= stab_q;
      cnt_q         <= cnt_d;
      col_valid_q   <= col_valid_d;
      col_idx_q     <= col_idx_d;
      multi_press_q <= multi_press_d;
      confirm_q     <= confirm_d;
      newgame_q     <= newgame_d;
    end
  end

  assign col_valid         = col_valid_q;
  assign col_idx           = col_idx_q;
  assign multi_press       = multi_press_q;
  assign confirm_pulse     = confirm_q;
  assign newgame_pulse     = newgame_q;
  assign switch_player_lvl = stab_prev_q[PIN_SWITCH];
  assign pvp_lvl           = stab_prev_q[PIN_PVP];
  assign debug_lvl         = stab_prev_q[PIN_DEBUG];

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4: stimulus queues expected
// pulse events with their arrival cycle, a monitor pops and compares them as they appear.
module tb_input_conditioner;

  localparam int unsigned LAT = 7;

  logic        clock;
  logic        reset;
  logic [11:0] pins_in;
  logic        col_valid;
  logic [2:0]  col_idx;
  logic        multi_press;
  logic        confirm_pulse;
  logic        newgame_pulse;
  logic        switch_player_lvl;
  logic        pvp_lvl;
  logic        debug_lvl;

  typedef struct {
    int unsigned cyc;
    logic        cv;
    logic [2:0]  idx;
    logic        mp;
    logic        cp;
    logic        ng;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          fails = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .pins_in           (pins_in),
    .col_valid         (col_valid),
    .col_idx           (col_idx),
    .multi_press       (multi_press),
    .confirm_pulse     (confirm_pulse),
    .newgame_pulse     (newgame_pulse),
    .switch_player_lvl (switch_player_lvl),
    .pvp_lvl           (pvp_lvl),
    .debug_lvl         (debug_lvl)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_evt(input logic cv, input logic [2:0] idx, input logic mp,
                            input logic cp, input logic ng);
    exp_t e;
    e.cyc = cyc + LAT;
    e.cv  = cv;
    e.idx = idx;
    e.mp  = mp;
    e.cp  = cp;
    e.ng  = ng;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation, on the expected cycle.
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      fails++;
      $display("FAIL missing_event: expected at cycle %0d, still absent at cycle %0d", sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (col_valid === 1'b1 || multi_press === 1'b1 || confirm_pulse === 1'b1 ||
        newgame_pulse === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: cycle %0d cv=%b idx=%0d mp=%b cp=%b ng=%b",
                 cyc, col_valid, col_idx, multi_press, confirm_pulse, newgame_pulse);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || col_valid !== e.cv || multi_press !== e.mp ||
            confirm_pulse !== e.cp || newgame_pulse !== e.ng ||
            (e.cv && col_idx !== e.idx)) begin
          fails++;
          $display("FAIL event: got cyc=%0d cv=%b idx=%0d mp=%b cp=%b ng=%b, required cyc=%0d cv=%b idx=%0d mp=%b cp=%b ng=%b",
                   cyc, col_valid, col_idx, multi_press, confirm_pulse, newgame_pulse,
                   e.cyc, e.cv, e.idx, e.mp, e.cp, e.ng);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    pins_in = 12'h000;
    step(3);
    chk("reset_outputs",
        {24'd0, col_valid, col_idx, multi_press, confirm_pulse, newgame_pulse},
        32'd0);
    chk("reset_levels", {29'd0, switch_player_lvl, pvp_lvl, debug_lvl}, 32'd0);
    reset = 1'b1;
    step(4);

    // Single clean column press, then release: one event only.
    pins_in[3] = 1'b1;
    expect_evt(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    step(14);
    pins_in[3] = 1'b0;
    step(12);
    chk("col_idx_hold_after_release", {29'd0, col_idx}, 32'd3);

    // Glitch of 3 cycles must be filtered.
    pins_in[5] = 1'b1;
    step(3);
    pins_in[5] = 1'b0;
    step(12);

    // Second column while first held: valid then multi_press, col_idx unchanged.
    pins_in[1] = 1'b1;
    expect_evt(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    step(10);
    pins_in[4] = 1'b1;
    expect_evt(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    step(12);
    chk("col_idx_hold_after_multi", {29'd0, col_idx}, 32'd1);
    pins_in[1] = 1'b0;
    step(10);
    pins_in[4] = 1'b0;
    step(12);

    // New game coincident with a column press discards the column.
    pins_in[10] = 1'b1;
    pins_in[2]  = 1'b1;
    expect_evt(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(12);
    pins_in[10] = 1'b0;
    pins_in[2]  = 1'b0;
    step(12);

    // New game coincident with confirm discards the confirm.
    pins_in[10] = 1'b1;
    pins_in[7]  = 1'b1;
    expect_evt(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(12);
    pins_in[10] = 1'b0;
    pins_in[7]  = 1'b0;
    step(12);

    // Confirm alongside a valid column press: both in the same cycle.
    pins_in[7] = 1'b1;
    pins_in[6] = 1'b1;
    expect_evt(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
    step(12);
    pins_in[7] = 1'b0;
    pins_in[6] = 1'b0;
    step(12);

    // Confirm alone, then new game alone.
    pins_in[7] = 1'b1;
    expect_evt(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    step(12);
    pins_in[7] = 1'b0;
    step(12);
    pins_in[10] = 1'b1;
    expect_evt(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(12);
    pins_in[10] = 1'b0;
    step(12);

    // Two columns pressed together: multi_press only.
    pins_in[0] = 1'b1;
    pins_in[6] = 1'b1;
    expect_evt(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    step(12);
    pins_in[0] = 1'b0;
    pins_in[6] = 1'b0;
    step(12);

    // Mode levels: exact latency on both edges, no pulses.
    pins_in[8]  = 1'b1;
    pins_in[9]  = 1'b1;
    pins_in[11] = 1'b1;
    step(LAT - 1);
    chk("levels_before_latency", {29'd0, switch_player_lvl, pvp_lvl, debug_lvl}, 32'd0);
    step(1);
    chk("levels_at_latency", {29'd0, switch_player_lvl, pvp_lvl, debug_lvl}, 32'd7);
    step(10);
    chk("levels_held", {29'd0, switch_player_lvl, pvp_lvl, debug_lvl}, 32'd7);
    pins_in[8]  = 1'b0;
    pins_in[11] = 1'b0;
    step(LAT - 1);
    chk("levels_fall_before_latency", {29'd0, switch_player_lvl, pvp_lvl, debug_lvl}, 32'd7);
    step(1);
    chk("levels_fall_at_latency", {29'd0, switch_player_lvl, pvp_lvl, debug_lvl}, 32'd2);
    pins_in[9] = 1'b0;
    step(12);

    // Reset mid-debounce with the button held: fresh press after full latency from release.
    pins_in[0] = 1'b1;
    step(4);
    reset = 1'b0;
    step(2);
    chk("mid_reset_outputs",
        {24'd0, col_valid, col_idx, multi_press, confirm_pulse, newgame_pulse},
        32'd0);
    reset = 1'b1;
    expect_evt(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    step(15);
    pins_in[0] = 1'b0;
    step(12);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
